// File: rtl/capture_controller_pkg.sv
// Shared state encoding and sample-buffer geometry for the capture controller.
package capture_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_WAIT_TRIG,
    ST_POSTTRIG,
    ST_DONE
  } cap_state_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/capture_controller_trigger_detect.sv
// Edge-style trigger: a sample fires only when it matches and the previous taken sample did not.
module capture_controller_trigger_detect
  import capture_controller_pkg::*;
#(
  parameter int CHANNEL_COUNT = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_COUNT-1:0] sample,
  input  logic [CHANNEL_COUNT-1:0] mask,
  input  logic [CHANNEL_COUNT-1:0] value,
  input  logic                     update,
  input  logic                     clear,
  output logic                     trigger
);

  logic match;
  logic prev_match;

  assign match = (((sample ^ value) & mask) == '0);
  // An empty mask means "trigger on the first sample evaluated", regardless of history.
  assign trigger = (mask == '0) || (match && !prev_match);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_match <= 1'b0;
    end else if (clear) begin
      prev_match <= 1'b0;
    end else if (update) begin
      prev_match <= match;
    end
  end

endmodule

// File: rtl/capture_controller.sv
// Logic-analyser style capture FSM: pre-trigger fill, circular wait, post-trigger fill, done.
module capture_controller
  import capture_controller_pkg::*;
#(
  parameter int CHANNEL_COUNT = 10,
  parameter int ADDR_WIDTH    = 10,
  parameter int PRE_TRIGGER   = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic [CHANNEL_COUNT-1:0] chan_in,
  input  logic [CHANNEL_COUNT-1:0] chan_enable,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [CHANNEL_COUNT-1:0] trig_mask,
  input  logic [CHANNEL_COUNT-1:0] trig_value,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [CHANNEL_COUNT-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]    start_addr,
  output logic                     capture_done,
  output logic                     busy
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int POST_COUNT = DEPTH - PRE_TRIGGER - 1;
  localparam logic [ADDR_WIDTH-1:0] PRE_LAST = ADDR_WIDTH'(PRE_TRIGGER - 1);
  localparam logic [ADDR_WIDTH-1:0] POST_LAST = ADDR_WIDTH'(POST_COUNT);

  cap_state_t              state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   pre_cnt;
  logic [ADDR_WIDTH-1:0]   post_cnt;
  logic [CHANNEL_COUNT-1:0] sample;
  logic                    take;
  logic                    accept_arm;
  logic                    trigger;

  assign sample     = chan_in & chan_enable;
  assign accept_arm = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));

  // Once the post-trigger quota is met, the remaining POSTTRIG cycle takes no samples.
  always_comb begin
    take = 1'b0;
    case (state)
      ST_PRETRIG:   take = sample_tick && (PRE_TRIGGER != 0);
      ST_WAIT_TRIG: take = sample_tick;
      ST_POSTTRIG:  take = sample_tick && (post_cnt != POST_LAST);
      default:      take = 1'b0;
    endcase
  end

  capture_controller_trigger_detect #(
    .CHANNEL_COUNT(CHANNEL_COUNT)
  ) u_trigger_detect (
    .clk    (clk),
    .reset  (reset),
    .sample (sample),
    .mask   (trig_mask),
    .value  (trig_value),
    .update (take),
    .clear  (accept_arm),
    .trigger(trigger)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      start_addr   <= '0;
      capture_done <= 1'b0;
      busy         <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (abort) begin
        state        <= ST_IDLE;
        busy         <= 1'b0;
        capture_done <= 1'b0;
      end else begin
        if (take) begin
          wr_en   <= 1'b1;
          wr_addr <= ptr;
          wr_data <= sample;
          ptr     <= ptr + 1'b1;
        end
        case (state)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              state        <= ST_PRETRIG;
              busy         <= 1'b1;
              capture_done <= 1'b0;
              ptr          <= '0;
              pre_cnt      <= '0;
            end
          end
          ST_PRETRIG: begin
            if (PRE_TRIGGER == 0) begin
              state <= ST_WAIT_TRIG;
            end else if (take) begin
              pre_cnt <= pre_cnt + 1'b1;
              if (pre_cnt == PRE_LAST) begin
                state <= ST_WAIT_TRIG;
              end
            end
          end
          ST_WAIT_TRIG: begin
            if (take && trigger) begin
              state    <= ST_POSTTRIG;
              post_cnt <= '0;
            end
          end
          ST_POSTTRIG: begin
            // ptr already points one past the last write, i.e. at the oldest sample kept.
            if (post_cnt == POST_LAST) begin
              state        <= ST_DONE;
              busy         <= 1'b0;
              capture_done <= 1'b1;
              start_addr   <= ptr;
            end else if (take) begin
              post_cnt <= post_cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
// Scoreboard bench: a sample-index model predicts every buffer write and each frame's start address.
module tb_capture_controller;

  localparam int C     = 4;
  localparam int AW    = 4;
  localparam int PRE   = 4;
  localparam int DEPTH = 16;
  localparam int POST  = DEPTH - PRE - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic [C-1:0]  chan_in;
  logic [C-1:0]  chan_enable;
  logic          arm;
  logic          abort;
  logic [C-1:0]  trig_mask;
  logic [C-1:0]  trig_value;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [C-1:0]  wr_data;
  logic [AW-1:0] start_addr;
  logic          capture_done;
  logic          busy;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [C-1:0]  data;
  } wr_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_start[$];
  logic [C-1:0]  pattern[64];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  bit            m_active = 0;
  int            m_n = 0;
  int            m_trig = -1;
  bit            m_prev = 0;
  logic [AW-1:0] last_start = '0;
  bit            done_seen = 0;
  wr_t           mon_e;

  always #5 clk = ~clk;

  capture_controller #(
    .CHANNEL_COUNT(C),
    .ADDR_WIDTH   (AW),
    .PRE_TRIGGER  (PRE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .chan_in     (chan_in),
    .chan_enable (chan_enable),
    .arm         (arm),
    .abort       (abort),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start_addr  (start_addr),
    .capture_done(capture_done),
    .busy        (busy)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model works per sample index: pre-trigger window, first edge-match after it, fixed post length.
  task automatic model_cycle();
    logic [C-1:0] s;
    bit mt;
    if (abort) begin
      m_active = 0;
    end else if (m_active && sample_tick) begin
      s  = chan_in & chan_enable;
      exp_wr.push_back('{addr: AW'(m_n % DEPTH), data: s});
      mt = (((s ^ trig_value) & trig_mask) == '0);
      if (m_trig < 0 && m_n >= PRE && (trig_mask == '0 || (mt && !m_prev))) m_trig = m_n;
      m_prev = mt;
      m_n++;
      if (m_trig >= 0 && m_n == m_trig + POST + 1) begin
        m_active = 0;
        exp_start.push_back(AW'(m_trig - PRE));
      end
    end else if (!m_active && arm) begin
      m_active = 1;
      m_n      = 0;
      m_trig   = -1;
      m_prev   = 0;
    end
  endtask

  task automatic applyStimulus(input logic a, input logic ab);
    @(negedge clk);
    sample_tick = (cyc % 3 == 0);
    arm         = a;
    abort       = ab;
    chan_in     = m_active ? pattern[(m_n < 64) ? m_n : 63] : pattern[0];
    model_cycle();
    cyc++;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!capture_done && k < 20) begin
      applyStimulus(1'b0, 1'b0);
      k++;
    end
    checkOutput("capture_done", capture_done, 1);
    checkOutput("busy_in_done", busy, 0);
  endtask

  // Runs one capture; gives up with an abort if the model sees no trigger within 40 samples.
  task automatic run_capture(input int rearm_at);
    int guard = 0;
    int rearm = rearm_at;
    applyStimulus(1'b1, 1'b0);
    while (m_active && !(m_trig < 0 && m_n >= 40) && guard < 400) begin
      if (rearm >= 0 && m_n == rearm) begin
        applyStimulus(1'b1, 1'b0);
        rearm = -1;
      end else begin
        applyStimulus(1'b0, 1'b0);
      end
      guard++;
    end
    if (m_active) begin
      applyStimulus(1'b0, 1'b1);
      repeat (2) applyStimulus(1'b0, 1'b0);
      checkOutput("busy_after_abort", busy, 0);
    end else begin
      wait_done();
    end
  endtask

  task automatic set_cfg(input logic [C-1:0] m, input logic [C-1:0] v, input logic [C-1:0] e);
    trig_mask   = m;
    trig_value  = v;
    chan_enable = e;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_wr_en"}, wr_en, 0);
    checkOutput({tag, "_wr_addr"}, wr_addr, 0);
    checkOutput({tag, "_wr_data"}, wr_data, 0);
    checkOutput({tag, "_start_addr"}, start_addr, 0);
    checkOutput({tag, "_capture_done"}, capture_done, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          checkOutput("unexpected_wr_en", 1, 0);
        end else begin
          mon_e = exp_wr.pop_front();
          checkOutput("wr_addr", wr_addr, mon_e.addr);
          checkOutput("wr_data", wr_data, mon_e.data);
        end
      end
      if (capture_done && !done_seen) begin
        checkOutput("writes_pending_at_done", exp_wr.size(), 0);
        if (exp_start.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          last_start = exp_start.pop_front();
          checkOutput("start_addr", start_addr, last_start);
        end
      end
    end
    done_seen = capture_done;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    sample_tick = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    chan_in = '0;
    set_cfg(4'b0001, 4'b0001, 4'b1111);
    for (int i = 0; i < 64; i++) pattern[i] = '0;
    repeat (3) applyStimulus(1'b0, 1'b0);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0);

    // ch0 rises at sample index 9
    for (int i = 0; i < 64; i++) pattern[i] = (C'($urandom()) & 4'b1110) | C'(i >= 9);
    run_capture(-1);
    checkOutput("rise9_start_addr", start_addr, 5);

    // ch0 high at arm, falls at 7, rises at 9
    for (int i = 0; i < 64; i++) pattern[i] = (C'($urandom()) & 4'b1110) | C'(i < 7 || i >= 9);
    run_capture(-1);
    checkOutput("high_at_arm_start_addr", start_addr, 5);

    // pulse during pre-trigger is ignored; real edge at 12
    for (int i = 0; i < 64; i++) pattern[i] = (C'($urandom()) & 4'b1110) | C'(i == 2 || i >= 12);
    run_capture(-1);
    checkOutput("pretrig_pulse_start_addr", start_addr, 8);

    // edge on the sample that completes pre-trigger is not accepted; next edge at 8
    for (int i = 0; i < 64; i++) pattern[i] = (C'($urandom()) & 4'b1110) | C'((i >= 3 && i < 6) || i >= 8);
    run_capture(-1);
    checkOutput("pretrig_last_start_addr", start_addr, 4);

    // empty mask triggers on the first wait-trigger sample
    set_cfg(4'b0000, 4'b0000, 4'b1111);
    for (int i = 0; i < 64; i++) pattern[i] = C'($urandom());
    run_capture(-1);
    checkOutput("mask0_start_addr", start_addr, 0);

    // disabled channels store zero
    set_cfg(4'b0000, 4'b0000, 4'b0101);
    for (int i = 0; i < 64; i++) pattern[i] = 4'b1111;
    run_capture(-1);
    checkOutput("enable_wr_data", wr_data, 4'b0101);

    // abort two cycles after arm, together with a tick
    set_cfg(4'b0001, 4'b0001, 4'b1111);
    for (int i = 0; i < 64; i++) pattern[i] = (C'($urandom()) & 4'b1110) | C'(i >= 9);
    while (cyc % 3 != 1) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("busy_after_arm", busy, 1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_wr_en", wr_en, 0);
    checkOutput("abort_capture_done", capture_done, 0);
    checkOutput("abort_start_addr_held", start_addr, last_start);
    repeat (3) applyStimulus(1'b0, 1'b0);

    // arm while busy is ignored
    run_capture(6);
    checkOutput("rearm_start_addr", start_addr, 5);

    // reset during post-trigger, then a clean capture
    set_cfg(4'b0000, 4'b0000, 4'b1111);
    for (int i = 0; i < 64; i++) pattern[i] = C'($urandom());
    applyStimulus(1'b1, 1'b0);
    while (m_active && !(m_trig >= 0 && m_n >= 7)) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    sample_tick = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    #2;
    reset = 1'b0;
    exp_wr.delete();
    exp_start.delete();
    m_active = 0;
    #1;
    check_all_zero("midreset");
    repeat (3) applyStimulus(1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0);
    run_capture(-1);
    checkOutput("post_reset_start_addr", start_addr, 0);

    // randomized captures
    for (int r = 0; r < 8; r++) begin
      set_cfg(C'($urandom_range(1, 15)) & C'($urandom()), C'($urandom()), C'($urandom()));
      for (int i = 0; i < 64; i++) pattern[i] = C'($urandom());
      run_capture(-1);
      repeat (2) applyStimulus(1'b0, 1'b0);
    end

    repeat (4) applyStimulus(1'b0, 1'b0);
    checkOutput("exp_wr_drained", exp_wr.size(), 0);
    checkOutput("exp_start_drained", exp_start.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
